// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues word fetches, tracks in-flight responses and
// buffers returned instructions in a small prefetch FIFO toward if_id.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_Clk,
  input  logic        i_reset,
  input  logic        i_jump_flag,
  input  logic [31:0] i_jump_addr,
  input  logic        i_hold_flag,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_pc_addr,
  output logic [31:0] o_inst_data,
  output logic        o_inst_valid
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    RESET_WAIT,
    FETCH,
    DRAIN
  } fetchState_t;

  fetchState_t      r_state;
  logic [31:0]      r_fetchPc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_discardCnt;

  // Address FIFO: remembers the pc of every granted request until it returns.
  logic [31:0]      r_addrFifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_addrRdPtr;
  logic [PTR_W-1:0] r_addrWrPtr;

  logic [31:0]      r_fifoPc   [FIFO_DEPTH];
  logic [31:0]      r_fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0] r_fifoRdPtr;
  logic [PTR_W-1:0] r_fifoWrPtr;
  logic [CNT_W-1:0] r_fifoCount;

  logic [CNT_W:0]   w_inFlight;
  logic             w_memReq;
  logic             w_grant;
  logic             w_rvalid;
  logic             w_instValid;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_respPc;
  logic [31:0]      w_jumpPc;
  logic [CNT_W-1:0] w_outstandingNext;
  logic [CNT_W-1:0] w_fifoCountNext;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits: buffered plus in-flight fetches never exceed the FIFO depth, so a
  // response always finds a free slot.
  assign w_inFlight  = {1'b0, r_outstanding} + {1'b0, r_fifoCount};
  assign w_memReq    = (r_state == FETCH) && (w_inFlight < {1'b0, CNT_MAX});
  assign w_grant     = w_memReq & i_mem_gnt;
  assign w_rvalid    = i_mem_rvalid && (r_outstanding != '0);
  assign w_instValid = (r_fifoCount != '0);
  assign w_respPc    = r_addrFifo[r_addrRdPtr];
  assign w_jumpPc    = i_jump_addr & WORD_MASK;

  // A jump wins over hold, over a returning response and over a pop.
  assign w_push = (r_state == FETCH) && w_rvalid && !i_jump_flag &&
                  ((r_fifoCount != CNT_MAX) || (w_instValid && !i_hold_flag));
  assign w_pop  = w_instValid && !i_hold_flag && !i_jump_flag;

  assign w_outstandingNext = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_rvalid);
  assign w_fifoCountNext   = r_fifoCount + CNT_W'(w_push) - CNT_W'(w_pop);

  assign o_mem_req    = w_memReq;
  assign o_mem_addr   = r_fetchPc;
  assign o_inst_valid = w_instValid;
  assign o_pc_addr    = w_instValid ? r_fifoPc[r_fifoRdPtr]   : 32'h0;
  assign o_inst_data  = w_instValid ? r_fifoData[r_fifoRdPtr] : 32'h0;

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      r_state       <= RESET_WAIT;
      r_fetchPc     <= RESET_PC & WORD_MASK;
      r_outstanding <= '0;
      r_discardCnt  <= '0;
      r_addrRdPtr   <= '0;
      r_addrWrPtr   <= '0;
      r_fifoRdPtr   <= '0;
      r_fifoWrPtr   <= '0;
      r_fifoCount   <= '0;
    end else begin
      if (w_grant) begin
        r_addrFifo[r_addrWrPtr] <= r_fetchPc;
        r_addrWrPtr             <= ptrInc(r_addrWrPtr);
      end
      if (w_rvalid) begin
        r_addrRdPtr <= ptrInc(r_addrRdPtr);
      end
      r_outstanding <= w_outstandingNext;

      if (i_jump_flag) begin
        r_fifoRdPtr <= '0;
        r_fifoWrPtr <= '0;
        r_fifoCount <= '0;
      end else begin
        if (w_push) begin
          r_fifoPc[r_fifoWrPtr]   <= w_respPc;
          r_fifoData[r_fifoWrPtr] <= i_mem_rdata;
          r_fifoWrPtr             <= ptrInc(r_fifoWrPtr);
        end
        if (w_pop) begin
          r_fifoRdPtr <= ptrInc(r_fifoRdPtr);
        end
        r_fifoCount <= w_fifoCountNext;
      end

      if (i_jump_flag) begin
        r_fetchPc <= w_jumpPc;
      end else if (w_grant) begin
        r_fetchPc <= r_fetchPc + 32'd4;
      end

      case (r_state)
        RESET_WAIT: begin
          r_discardCnt <= '0;
          r_state      <= FETCH;
        end
        FETCH: begin
          // Everything still in flight after this edge belongs to the old path.
          if (i_jump_flag) begin
            r_discardCnt <= w_outstandingNext;
            r_state      <= (w_outstandingNext != '0) ? DRAIN : FETCH;
          end
        end
        DRAIN: begin
          if (r_discardCnt == '0) begin
            r_state <= FETCH;
          end else if (w_rvalid) begin
            r_discardCnt <= r_discardCnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= RESET_WAIT;
        end
      endcase
    end
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: prefetch buffer entries, which is also the maximum number of in-flight plus buffered fetches.
REQ-003 i_Clk  input  1  single clock; all state updates on posedge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_jump_flag  input  1  redirect from ex; valid for one cycle.
REQ-006 i_jump_addr  input  32  redirect target.
REQ-007 i_hold_flag  input  1  downstream stall; the output instruction must not advance.
REQ-008 o_mem_req  output  1  instruction memory request.
REQ-009 o_mem_addr  output  32  request address; word aligned.
REQ-010 i_mem_gnt  input  1  request accepted this cycle when o_mem_req=1.
REQ-011 i_mem_rvalid  input  1  read data valid; responses return in request order, latency >=1.
REQ-012 i_mem_rdata  input  32  read data.
REQ-013 o_pc_addr  output  32  pc of the presented instruction, to if_id.
REQ-014 o_inst_data  output  32  presented instruction, to if_id.
REQ-015 o_inst_valid  output  1  o_pc_addr/o_inst_data valid.

Function
REQ-016 States: RESET_WAIT, FETCH, DRAIN.
- RESET_WAIT: entered on reset, lasts 1 cycle, then goes to FETCH.
REQ-017 Fetch pc register: loaded with RESET_PC on reset; advances by 4 on each grant (o_mem_req & i_mem_gnt).
REQ-018 In FETCH, o_mem_req=1 iff outstanding + fifo_count < FIFO_DEPTH; o_mem_addr = fetch pc.
- o_mem_req and o_mem_addr hold stable until granted.
REQ-019 Each granted request increments the outstanding count; each rvalid decrements it.
- The response pc equals the request address, tracked in an address FIFO of FIFO_DEPTH entries.
REQ-020 In FETCH, rvalid pushes {pc, rdata} into the prefetch FIFO in the same cycle.
- The pushed entry is presentable the next cycle; latency from grant to o_inst_valid is mem latency + 1.
REQ-021 o_inst_valid=1 iff the FIFO is non-empty.
- o_pc_addr/o_inst_data show the FIFO head when valid, 32'h0 otherwise.
REQ-022 Pop: o_inst_valid & !i_hold_flag pops the head.
- While i_hold_flag=1 the head and the outputs are unchanged.
REQ-023 FIFO full:
- No new request is issued.
- A response can never arrive to a full FIFO, since credits count outstanding requests.
REQ-024 Push and pop in the same cycle keep fifo_count unchanged; the pointers wrap modulo FIFO_DEPTH.
REQ-025 Jump handling, when i_jump_flag=1:
- The FIFO is flushed and o_inst_valid=0 from the next cycle.
- The fetch pc is loaded with {i_jump_addr[31:2], 2'b00}.
- discard_cnt is loaded with outstanding, including any grant in the same cycle, minus any rvalid in the same cycle.
- The next state is DRAIN if discard_cnt > 0, else FETCH.
REQ-026 A jump has priority over hold, over a simultaneous rvalid (that data is dropped) and over a simultaneous pop.
REQ-027 DRAIN:
- o_mem_req=0.
- Each rvalid decrements discard_cnt and its data is discarded.
- Transition to FETCH in the cycle after discard_cnt reaches 0.
- A jump in DRAIN reloads the fetch pc and keeps discarding.
REQ-028 A grant while o_mem_req=0 and an rvalid with outstanding=0 are ignored; neither counter may underflow.

Reset
REQ-029 On i_reset=1 at posedge, regardless of state or in-flight fetches:
- state=RESET_WAIT.
- FIFO emptied, outstanding=0, discard_cnt=0.
- Fetch pc=RESET_PC.
- o_mem_req=0, o_inst_valid=0, o_pc_addr=0, o_inst_data=0.
REQ-030 Responses to requests made before reset are not tracked; the memory is reset in the same cycle.

Verification
REQ-031 Reset, then gnt always 1 with 1-cycle latency:
- requests at addresses 0x0, 0x4, 0x8, ...
- o_inst_valid first rises 3 cycles after reset release, with o_pc_addr=0x0.
REQ-032 Hold with gnt always 1:
- hold=1 for 4 cycles at pc 0x8: outputs stay at 0x8.
- o_mem_req drops once 2 entries are buffered or outstanding.
- After release, 0x8, 0xC are presented on consecutive cycles.
REQ-033 Jump with 2 requests outstanding:
- jump to 0x103 -> fetch restarts at 0x100 after both stale responses are discarded.
- Stale data never appears on the outputs.
REQ-034 Jump coincident with rvalid and pop -> that data is dropped, the FIFO is empty next cycle, no underflow.
REQ-035 gnt stuck at 0 for 10 cycles -> o_mem_req and o_mem_addr are held stable, and o_inst_valid drops once the FIFO drains.
REQ-036 Reset asserted in DRAIN with discard_cnt=1 -> all outputs 0 next cycle, then fetch resumes at RESET_PC.
